// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite bus bundle shared by a single master and a single slave.
// The slave modport is the view used by axi4_lite_slave.
interface axi4lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      AW_VALID;
  logic                      AW_READY;
  logic [ADDR_WIDTH-1:0]     AW_ADDR;
  logic [2:0]                AW_PROT;
  logic                      W_VALID;
  logic                      W_READY;
  logic [DATA_WIDTH-1:0]     W_DATA;
  logic [DATA_WIDTH/8-1:0]   W_STRB;
  logic                      B_VALID;
  logic                      B_READY;
  logic [1:0]                B_RESP;
  logic                      AR_VALID;
  logic                      AR_READY;
  logic [ADDR_WIDTH-1:0]     AR_ADDR;
  logic [2:0]                AR_PROT;
  logic                      R_VALID;
  logic                      R_READY;
  logic [DATA_WIDTH-1:0]     R_DATA;
  logic [1:0]                R_RESP;

  modport slave (
    input  AW_VALID, AW_ADDR, AW_PROT,
    output AW_READY,
    input  W_VALID, W_DATA, W_STRB,
    output W_READY,
    output B_VALID, B_RESP,
    input  B_READY,
    input  AR_VALID, AR_ADDR, AR_PROT,
    output AR_READY,
    output R_VALID, R_DATA, R_RESP,
    input  R_READY
  );

  modport master (
    output AW_VALID, AW_ADDR, AW_PROT,
    input  AW_READY,
    output W_VALID, W_DATA, W_STRB,
    input  W_READY,
    input  B_VALID, B_RESP,
    output B_READY,
    output AR_VALID, AR_ADDR, AR_PROT,
    input  AR_READY,
    input  R_VALID, R_DATA, R_RESP,
    output R_READY
  );
endinterface

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave over a small word-addressed register file.
// Read and write channels run independent FSMs sharing one memory array.
module axi4_lite_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 16
) (
  input  logic       A_CLK,
  input  logic       A_RSTn,
  axi4lite_if.slave  axi
);
  localparam int                    IDX_W      = $clog2(MEM_DEPTH);
  localparam int                    STRB_W     = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_DEPTH * 4);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic       {RD_IDLE, RD_RESP}            rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_COMMIT, WR_RESP} wr_state_t;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return addr < ADDR_LIMIT;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[IDX_W+1:2];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  rd_state_t             rd_state, rd_next;
  logic                  r_load, r_done;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;

  wr_state_t             wr_state, wr_next;
  logic                  aw_got, w_got;
  logic                  aw_ready, w_ready;
  logic                  aw_hs, w_hs, mem_we, b_done;
  logic                  b_valid;
  logic [1:0]            b_resp;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  // Protection attributes carry no meaning for this target.
  logic unused_prot;
  assign unused_prot = ^{axi.AW_PROT, axi.AR_PROT};

  // ---- read channel ----
  always_comb begin
    rd_next = rd_state;
    r_load  = 1'b0;
    r_done  = 1'b0;
    unique case (rd_state)
      RD_IDLE: if (axi.AR_VALID) begin
        r_load  = 1'b1;
        rd_next = RD_RESP;
      end
      RD_RESP: if (axi.R_READY) begin
        r_done  = 1'b1;
        rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      rd_state <= RD_IDLE;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_resp   <= RESP_OKAY;
    end else begin
      rd_state <= rd_next;
      if (r_load) begin
        r_valid <= 1'b1;
        if (in_range(axi.AR_ADDR)) begin
          r_data <= mem[word_idx(axi.AR_ADDR)];
          r_resp <= RESP_OKAY;
        end else begin
          r_data <= '0;
          r_resp <= RESP_SLVERR;
        end
      end else if (r_done) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign axi.AR_READY = (rd_state == RD_IDLE);
  assign axi.R_VALID  = r_valid;
  assign axi.R_DATA   = r_data;
  assign axi.R_RESP   = r_resp;

  // ---- write channel: AW and W captured independently, then one commit edge ----
  always_comb begin
    wr_next  = wr_state;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    mem_we   = 1'b0;
    b_done   = 1'b0;
    unique case (wr_state)
      WR_IDLE: begin
        aw_ready = !aw_got;
        w_ready  = !w_got;
        if ((aw_got || (axi.AW_VALID && aw_ready)) && (w_got || (axi.W_VALID && w_ready)))
          wr_next = WR_COMMIT;
      end
      WR_COMMIT: begin
        mem_we  = in_range(aw_addr_q);
        wr_next = WR_RESP;
      end
      WR_RESP: if (axi.B_READY) begin
        b_done  = 1'b1;
        wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
    aw_hs = axi.AW_VALID && aw_ready;
    w_hs  = axi.W_VALID && w_ready;
  end

  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      wr_state <= WR_IDLE;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      b_valid  <= 1'b0;
      b_resp   <= RESP_OKAY;
    end else begin
      wr_state <= wr_next;
      if (aw_hs) aw_got <= 1'b1;
      if (w_hs)  w_got  <= 1'b1;
      if (wr_state == WR_COMMIT) begin
        aw_got  <= 1'b0;
        w_got   <= 1'b0;
        b_valid <= 1'b1;
        b_resp  <= in_range(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
      end else if (b_done) begin
        b_valid <= 1'b0;
      end
    end
  end

  // Captured address/data need no reset: aw_got/w_got qualify them.
  always_ff @(posedge A_CLK) begin
    if (aw_hs) aw_addr_q <= axi.AW_ADDR;
    if (w_hs) begin
      w_data_q <= axi.W_DATA;
      w_strb_q <= axi.W_STRB;
    end
  end

  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[word_idx(aw_addr_q)] <= merge_lanes(mem[word_idx(aw_addr_q)], w_data_q, w_strb_q);
    end
  end

  assign axi.AW_READY = aw_ready;
  assign axi.W_READY  = w_ready;
  assign axi.B_VALID  = b_valid;
  assign axi.B_RESP   = b_resp;
endmodule

// File: tb/tb_axi4_lite_slave.sv
// Bench for axi4_lite_slave: directed scenarios plus random traffic
// checked against a byte-lane memory model.
module tb_axi4_lite_slave;
  localparam int MEM_DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(MEM_DEPTH)) dut (
    .A_CLK (clk),
    .A_RSTn(rst_n),
    .axi   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] ref_mem [MEM_DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = 32'h0;
  endtask

  task automatic ref_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int w;
    if (addr >= 32'(MEM_DEPTH * 4)) begin
      resp = 2'b10;
    end else begin
      resp = 2'b00;
      w = int'(addr) / 4;
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic ref_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    if (addr >= 32'(MEM_DEPTH * 4)) begin
      data = 32'h0;
      resp = 2'b10;
    end else begin
      data = ref_mem[int'(addr) / 4];
      resp = 2'b00;
    end
  endtask

  // All driving happens at negedge; the DUT samples at the next posedge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_lag, input int w_lag, input bit b_hold,
                           input logic [1:0] exp_resp);
    bit aw_done, w_done, aw_fire, w_fire;
    int t, n;
    aw_done = 0; w_done = 0; t = 0;
    bus.B_READY = !b_hold;
    bus.AW_ADDR = addr; bus.W_DATA = data; bus.W_STRB = strb;
    bus.AW_PROT = 3'($urandom); bus.AR_PROT = 3'($urandom);
    while (!(aw_done && w_done) && t < 50) begin
      bus.AW_VALID = !aw_done && (t >= aw_lag);
      bus.W_VALID  = !w_done && (t >= w_lag);
      aw_fire = bus.AW_VALID && bus.AW_READY;
      w_fire  = bus.W_VALID && bus.W_READY;
      @(posedge clk); @(negedge clk);
      aw_done = aw_done | aw_fire;
      w_done  = w_done | w_fire;
      t++;
    end
    bus.AW_VALID = 1'b0;
    bus.W_VALID  = 1'b0;
    chk("wr_capture", 32'(aw_done && w_done), 32'd1);
    chk("b_valid_before_commit", 32'(bus.B_VALID), 32'd0);
    n = 0;
    while (!bus.B_VALID && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    chk("b_latency", 32'(n), 32'd1);
    chk("b_resp", 32'(bus.B_RESP), 32'(exp_resp));
    if (!b_hold) begin
      @(posedge clk); @(negedge clk);
      chk("b_valid_after_hs", 32'(bus.B_VALID), 32'd0);
      chk("aw_w_ready_idle", 32'({bus.AW_READY, bus.W_READY}), 32'd3);
      bus.B_READY = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_delay,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    bit fire;
    int t;
    fire = 0; t = 0;
    bus.R_READY  = (r_delay == 0);
    bus.AR_ADDR  = addr;
    bus.AR_PROT  = 3'($urandom);
    bus.AR_VALID = 1'b1;
    while (!fire && t < 50) begin
      fire = bus.AR_READY;
      @(posedge clk); @(negedge clk);
      t++;
    end
    bus.AR_VALID = 1'b0;
    chk("ar_accept", 32'(fire), 32'd1);
    chk("r_valid_latency", 32'(bus.R_VALID), 32'd1);
    chk("r_data", bus.R_DATA, exp_data);
    chk("r_resp", 32'(bus.R_RESP), 32'(exp_resp));
    chk("ar_ready_busy", 32'(bus.AR_READY), 32'd0);
    for (int i = 0; i < r_delay; i++) begin
      @(posedge clk); @(negedge clk);
      chk("r_valid_hold", 32'(bus.R_VALID), 32'd1);
      chk("r_data_hold", bus.R_DATA, exp_data);
      chk("r_resp_hold", 32'(bus.R_RESP), 32'(exp_resp));
      chk("ar_ready_hold", 32'(bus.AR_READY), 32'd0);
    end
    bus.R_READY = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("r_valid_after_hs", 32'(bus.R_VALID), 32'd0);
    chk("ar_ready_after_hs", 32'(bus.AR_READY), 32'd1);
    bus.R_READY = 1'b0;
  endtask

  initial begin
    logic [31:0] addr, data, exp_d;
    logic [3:0]  strb;
    logic [1:0]  resp;

    bus.AW_VALID = 0; bus.AW_ADDR = 0; bus.AW_PROT = 0;
    bus.W_VALID = 0;  bus.W_DATA = 0;  bus.W_STRB = 0;
    bus.B_READY = 0;
    bus.AR_VALID = 0; bus.AR_ADDR = 0; bus.AR_PROT = 0;
    bus.R_READY = 0;
    ref_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_ar_ready", 32'(bus.AR_READY), 32'd1);
    chk("rst_aw_ready", 32'(bus.AW_READY), 32'd1);
    chk("rst_w_ready", 32'(bus.W_READY), 32'd1);
    chk("rst_r_valid", 32'(bus.R_VALID), 32'd0);
    chk("rst_b_valid", 32'(bus.B_VALID), 32'd0);
    chk("rst_r_data", bus.R_DATA, 32'h0);

    axi_read(32'h1, 0, 32'h0, 2'b00);

    ref_write(32'h4, 32'hDEADBEEF, 4'hF, resp);
    axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp);
    axi_read(32'h4, 0, 32'hDEADBEEF, 2'b00);

    ref_write(32'h1, 32'h1, 4'h0, resp);
    axi_write(32'h1, 32'h1, 4'h0, 0, 0, 0, 2'b00);
    axi_read(32'h1, 0, 32'h0, 2'b00);

    ref_write(32'h4, 32'h0000AB00, 4'b0010, resp);
    axi_write(32'h4, 32'h0000AB00, 4'b0010, 3, 0, 0, resp);
    axi_read(32'h4, 0, 32'hDEADABEF, 2'b00);

    axi_read(32'h4, 4, 32'hDEADABEF, 2'b00);

    axi_read(32'h40, 1, 32'h0, 2'b10);
    ref_write(32'h40, 32'hFFFFFFFF, 4'hF, resp);
    axi_write(32'h40, 32'hFFFFFFFF, 4'hF, 1, 0, 0, 2'b10);
    for (int i = 0; i < MEM_DEPTH; i++) begin
      ref_read(32'(i * 4), exp_d, resp);
      axi_read(32'(i * 4), 0, exp_d, resp);
    end

    // Leave a write response pending, then reset asynchronously mid-cycle.
    ref_write(32'h8, 32'h12345678, 4'hF, resp);
    axi_write(32'h8, 32'h12345678, 4'hF, 0, 0, 1, resp);
    chk("b_valid_pending", 32'(bus.B_VALID), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_b_valid", 32'(bus.B_VALID), 32'd0);
    chk("rst_async_aw_ready", 32'(bus.AW_READY), 32'd1);
    bus.B_READY = 1'b0;
    ref_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(32'h4, 0, 32'h0, 2'b00);
    axi_read(32'h8, 0, 32'h0, 2'b00);

    for (int i = 0; i < 40; i++) begin
      addr = 32'($urandom_range(0, 79));
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        ref_write(addr, data, strb, resp);
        axi_write(addr, data, strb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, resp);
      end else begin
        ref_read(addr, exp_d, resp);
        axi_read(addr, int'($urandom_range(0, 2)), exp_d, resp);
      end
    end
    for (int i = 0; i < MEM_DEPTH; i++) begin
      ref_read(32'(i * 4), exp_d, resp);
      axi_read(32'(i * 4), 0, exp_d, resp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
